// File: rtl/vector_alu_sequencer.sv
// Sequences one vector operation through an external shared scalar ALU, one lane per cycle.
// Divide-by-zero lanes are resolved locally and the ALU result for them is discarded.
//
// state | meaning
// IDLE  | waiting for start_i; results held
// RUN   | one lane per cycle through the shared ALU
// FIN   | done_o pulse, back to IDLE
module vector_alu_sequencer #(
  parameter int BITS  = 32,
  parameter int LANES = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    start_i,
  input  logic [1:0]              op_i,
  input  logic [LANES*BITS-1:0]   va_i,
  input  logic [LANES*BITS-1:0]   vb_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [LANES*BITS-1:0]   vout_o,
  output logic [2*LANES-1:0]      vflags_o,
  output logic                    divz_o,
  output logic [BITS-1:0]         alu_in0_o,
  output logic [BITS-1:0]         alu_in1_o,
  output logic [1:0]              alu_op_o,
  input  logic [BITS-1:0]         alu_out_i,
  input  logic [1:0]              alu_flags_i
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
  localparam logic [1:0] OP_DIV = 2'b11;
  localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

  logic [1:0]            state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [LANES*BITS-1:0] va_q, va_d;
  logic [LANES*BITS-1:0] vb_q, vb_d;
  logic [1:0]            op_q, op_d;
  logic [LANES*BITS-1:0] vout_q, vout_d;
  logic [2*LANES-1:0]    vflags_q, vflags_d;
  logic                  divz_q, divz_d;

  logic [BITS-1:0] lane_a;
  logic [BITS-1:0] lane_b;
  logic            lane_divz;
  logic            running;

  assign running   = (state_q == S_RUN);
  assign lane_a    = va_q[idx_q*BITS +: BITS];
  assign lane_b    = vb_q[idx_q*BITS +: BITS];
  assign lane_divz = (op_q == OP_DIV) && (lane_b == '0);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    va_d     = va_q;
    vb_d     = vb_q;
    op_d     = op_q;
    vout_d   = vout_q;
    vflags_d = vflags_q;
    divz_d   = divz_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          va_d    = va_i;
          vb_d    = vb_i;
          op_d    = op_i;
          idx_d   = '0;
          divz_d  = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // zero divisor: force result 0 with Z set, ignore whatever the ALU returns
        if (lane_divz) begin
          vout_d[idx_q*BITS +: BITS] = '0;
          vflags_d[idx_q*2 +: 2]     = 2'b10;
          divz_d                     = 1'b1;
        end else begin
          vout_d[idx_q*BITS +: BITS] = alu_out_i;
          vflags_d[idx_q*2 +: 2]     = alu_flags_i;
        end
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_FIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      va_q     <= '0;
      vb_q     <= '0;
      op_q     <= '0;
      vout_q   <= '0;
      vflags_q <= '0;
      divz_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      va_q     <= va_d;
      vb_q     <= vb_d;
      op_q     <= op_d;
      vout_q   <= vout_d;
      vflags_q <= vflags_d;
      divz_q   <= divz_d;
    end
  end

  assign busy_o    = running;
  assign done_o    = (state_q == S_FIN);
  assign vout_o    = vout_q;
  assign vflags_o  = vflags_q;
  assign divz_o    = divz_q;
  assign alu_in0_o = running ? lane_a : '0;
  assign alu_in1_o = running ? lane_b : '0;
  assign alu_op_o  = running ? op_q : 2'b00;

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Bench for vector_alu_sequencer: provides the shared ALU, runs directed vectors,
// multi-cycle corner sequences and random operations against a lane-wise reference model.
module tb_vector_alu_sequencer;
  localparam int BITS  = 32;
  localparam int LANES = 4;
  localparam int W     = BITS * LANES;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [1:0]           op_r;
  logic [W-1:0]         va_r, vb_r;
  logic                 busy, done, divz;
  logic [W-1:0]         vout;
  logic [2*LANES-1:0]   vflags;
  logic [BITS-1:0]      alu_in0, alu_in1, alu_out;
  logic [1:0]           alu_op, alu_flags;

  int total = 0;
  int bad   = 0;

  vector_alu_sequencer #(.BITS(BITS), .LANES(LANES)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .op_i(op_r),
    .va_i(va_r), .vb_i(vb_r), .busy_o(busy), .done_o(done),
    .vout_o(vout), .vflags_o(vflags), .divz_o(divz),
    .alu_in0_o(alu_in0), .alu_in1_o(alu_in1), .alu_op_o(alu_op),
    .alu_out_i(alu_out), .alu_flags_i(alu_flags)
  );

  always #5 clk = ~clk;

  // shared ALU; divide by zero returns junk that the sequencer must discard
  always_comb begin
    alu_out = '0;
    case (alu_op)
      2'b00: alu_out = alu_in0 + alu_in1;
      2'b01: alu_out = alu_in0 - alu_in1;
      2'b10: alu_out = alu_in0 * alu_in1;
      default: alu_out = (alu_in1 == '0) ? 32'hFFFF_FFFF : alu_in0 / alu_in1;
    endcase
    alu_flags = {alu_out == '0, alu_out[BITS-1]};
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op, input logic [W-1:0] va, input logic [W-1:0] vb,
                                output logic [W-1:0] vo, output logic [2*LANES-1:0] vf, output logic dz);
    logic [BITS-1:0] a, b, r;
    logic [63:0] p;
    vo = '0; vf = '0; dz = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      a = va[i*BITS +: BITS];
      b = vb[i*BITS +: BITS];
      r = '0;
      case (op)
        2'b00: r = a + b;
        2'b01: r = a - b;
        2'b10: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
        default: if (b == '0) dz = 1'b1; else r = a / b;
      endcase
      vo[i*BITS +: BITS] = r;
      vf[2*i +: 2]       = {r == '0, r[BITS-1]};
    end
  endfunction

  // one full operation; operands scrambled during RUN, START re-raised during DONE
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] va, input logic [W-1:0] vb,
                       output logic [W-1:0] vo, output logic [2*LANES-1:0] vf, output logic dz);
    logic [W-1:0] ev;
    logic [2*LANES-1:0] ef;
    logic edz;
    int n, runs;
    model(op, va, vb, ev, ef, edz);
    @(negedge clk);
    start = 1'b1; op_r = op; va_r = va; vb_r = vb;
    @(negedge clk);
    start = 1'b0;
    chk("divz_cleared_on_start", divz, '0);
    runs = 0; n = 0;
    while (!done && n < 3*LANES) begin
      if (busy) begin
        chk("alu_in0", alu_in0, va[runs*BITS +: BITS]);
        chk("alu_in1", alu_in1, vb[runs*BITS +: BITS]);
        chk("alu_op", alu_op, op);
        runs++;
      end
      va_r = {$urandom, $urandom, $urandom, $urandom};
      vb_r = {$urandom, $urandom, $urandom, $urandom};
      op_r = 2'($urandom);
      n++;
      @(negedge clk);
    end
    chk("done_seen", done, 1);
    chk("run_cycles", runs, LANES);
    chk("busy_in_fin", busy, 0);
    chk("vout", vout, ev);
    chk("vflags", vflags, ef);
    chk("divz", divz, edz);
    vo = vout; vf = vflags; dz = divz;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("start_on_done_ignored", busy, 0);
    chk("idle_alu_zero", {alu_in0, alu_in1, alu_op}, '0);
    @(negedge clk);
    chk("vout_hold", vout, ev);
    chk("divz_hold", divz, edz);
  endtask

  typedef struct {
    logic [1:0]         op;
    logic [W-1:0]       va, vb, vout;
    logic [2*LANES-1:0] vflags;
    logic               divz;
  } vec_t;

  vec_t tbl[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] vo, va_x, vb_x, ev;
    logic [2*LANES-1:0] vf, ef;
    logic dz, edz;
    int dones, first_done, last_done, spacing_bad;

    tbl[0] = '{2'b00, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd1, 32'd1, 32'd1, 32'd1},
               {32'd5, 32'd4, 32'd3, 32'd2}, 8'h00, 1'b0};
    tbl[1] = '{2'b01, {32'd0, 32'd5, 32'd1, 32'd7}, {32'd0, 32'd5, 32'd2, 32'd7},
               {32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0}, 8'hA6, 1'b0};
    tbl[2] = '{2'b11, {32'd8, 32'd8, 32'd8, 32'd8}, {32'd2, 32'd0, 32'd4, 32'd0},
               {32'd4, 32'd0, 32'd2, 32'd0}, 8'h22, 1'b1};
    tbl[3] = '{2'b10, {32'd1, 32'd2, 32'h1_0000, 32'hFFFF_FFFF}, {32'd5, 32'd0, 32'h1_0000, 32'd2},
               {32'd5, 32'd0, 32'd0, 32'hFFFF_FFFE}, 8'h29, 1'b0};

    rst_n = 1'b0; start = 1'b0; op_r = '0; va_r = '0; vb_r = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", {busy, done, divz, vflags, alu_in0, alu_in1, alu_op}, '0);
    chk("reset_vout", vout, '0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      do_op(tbl[i].op, tbl[i].va, tbl[i].vb, vo, vf, dz);
      chk("tbl_vout", vo, tbl[i].vout);
      chk("tbl_vflags", vf, tbl[i].vflags);
      chk("tbl_divz", dz, tbl[i].divz);
    end

    // START held high: one operation every 6 cycles, first result from the first latched operands
    va_x = {32'd10, 32'd20, 32'd30, 32'd40};
    vb_x = {32'd1, 32'd2, 32'd3, 32'd4};
    model(2'b01, va_x, vb_x, ev, ef, edz);
    @(negedge clk);
    start = 1'b1; op_r = 2'b01; va_r = va_x; vb_r = vb_x;
    dones = 0; first_done = -1; last_done = -1; spacing_bad = 0;
    for (int m = 0; m < 20; m++) begin
      @(negedge clk);
      va_r = {$urandom, $urandom, $urandom, $urandom};
      if (done) begin
        if (dones == 0) begin
          first_done = m;
          chk("held_start_first_vout", vout, ev);
        end else if (m - last_done != 6) begin
          spacing_bad++;
        end
        last_done = m;
        dones++;
      end
    end
    start = 1'b0;
    chk("held_start_dones", dones, 3);
    chk("held_start_first_done", first_done, 4);
    chk("held_start_spacing", spacing_bad, 0);
    repeat (8) @(negedge clk);

    // reset in the second RUN cycle aborts silently
    @(negedge clk);
    start = 1'b1; op_r = 2'b11; va_r = {4{32'd9}}; vb_r = {32'd3, 32'd3, 32'd3, 32'd0};
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("divz_before_abort", divz, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_ctrl", {busy, done, divz, vflags, alu_in0, alu_in1, alu_op}, '0);
    chk("abort_vout", vout, '0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int m = 0; m < 8; m++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    chk("no_done_after_abort", dones, 0);
    do_op(2'b00, {32'd100, 32'd200, 32'd300, 32'd400}, {4{32'd1}}, vo, vf, dz);
    chk("post_abort_vout", vo, {32'd101, 32'd201, 32'd301, 32'd401});

    for (int r = 0; r < 40; r++) begin
      logic [1:0] rop;
      logic [W-1:0] rva, rvb;
      rop = 2'($urandom_range(0, 3));
      rva = {$urandom, $urandom, $urandom, $urandom};
      for (int l = 0; l < LANES; l++) begin
        if ($urandom_range(0, 3) == 0) rvb[l*BITS +: BITS] = '0;
        else if (rop == 2'b11) rvb[l*BITS +: BITS] = $urandom_range(1, 1000);
        else rvb[l*BITS +: BITS] = $urandom;
      end
      do_op(rop, rva, rvb, vo, vf, dz);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
